selfcomp_checker: RTL and testbench

Parametrised self-composition checker that monitors NUM_COPIES identical SE instances fed the same instruction stream with differing secret inputs. It accepts each copy's result through a valid/ready handshake and measures the cycle skew between the first and last completion. Per transaction it reports timing divergence, completion and (optionally) result divergence as sticky flags. It sits between the SE copies' output ports and the self-composition property harness.

---
 rtl/selfcomp_checker.sv | 201 ++++++++++++++++++++
 tb/tb_selfcomp_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/selfcomp_checker.sv
// selfcomp_checker: watches NUM_COPIES SE copies, measures completion skew and flags timing/value divergence (value check built only with SELFCOMP_VALUE_CHECK_EN).
// Latency: report pulse (timingLeakDone) one cycle after the last copy is accepted; HALT after MAX_SKEW cycles of waiting in COLLECT.
// Backpressure: ready drops per copy once captured, all ready low during REPORT, all ready high (drain) while in HALT.
module selfcomp_checker #(
    parameter int NUM_COPIES = 2,
    parameter int DATA_W     = 128,
    parameter int MAX_SKEW   = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_COPIES-1:0]        io_copy_valid,
    input  logic [NUM_COPIES*DATA_W-1:0] io_copy_result,
    output logic [NUM_COPIES-1:0]        io_copy_ready,
    input  logic                         io_clear,
    output logic                         timingLeak,
    output logic                         valueLeak,
    output logic                         timeout,
    output logic                         timingLeakDone,
    output logic                         allValid,
    output logic [7:0]                   leakSkew,
    output logic [15:0]                  txnCount
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_REPORT, S_HALT} state_t;

    state_t                state_q, state_d;
    logic [NUM_COPIES-1:0] captured_q, captured_d;
    logic [NUM_COPIES-1:0] accept;
    logic [7:0]            cnt_q, cnt_d;
    logic [8:0]            cnt_inc;
    logic [7:0]            skew_sat;
    logic                  mismatch_q, mismatch_d;
    logic                  mis_now;
    logic                  timing_leak_q, timing_leak_d;
    logic                  value_leak_q, value_leak_d;
    logic                  timeout_q, timeout_d;
    logic                  done_q, done_d;
    logic                  all_valid_q, all_valid_d;
    logic [7:0]            leak_skew_q, leak_skew_d;
    logic [15:0]           txn_count_q, txn_count_d;
    logic                  report;
    logic [7:0]            rep_skew;

    // Ready depends only on registered state so there is no valid-to-ready path.
    always_comb begin
        io_copy_ready = '1;
        case (state_q)
            S_IDLE, S_COLLECT: io_copy_ready = ~captured_q;
            S_REPORT:          io_copy_ready = '0;
            default:           io_copy_ready = '1;
        endcase
    end

    assign accept   = io_copy_valid & io_copy_ready;
    assign cnt_inc  = {1'b0, cnt_q} + 9'd1;
    assign skew_sat = cnt_inc[8] ? 8'hFF : cnt_inc[7:0];

`ifdef SELFCOMP_VALUE_CHECK_EN
    logic [DATA_W-1:0] ref_q, ref_d;
    logic              found;

    // In IDLE the lowest-index accepted result becomes the reference; every accept is compared against it.
    always_comb begin
        ref_d   = ref_q;
        found   = 1'b0;
        mis_now = 1'b0;
        if (state_q == S_IDLE) begin
            for (int i = 0; i < NUM_COPIES; i++) begin
                if (accept[i] && !found) begin
                    ref_d = io_copy_result[i*DATA_W +: DATA_W];
                    found = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_COPIES; i++) begin
            if (accept[i] && (io_copy_result[i*DATA_W +: DATA_W] != ref_d)) begin
                mis_now = 1'b1;
            end
        end
    end

    // Reference result register.
    always_ff @(posedge clock) begin
        if (reset) ref_q <= '0;
        else       ref_q <= ref_d;
    end
`else
    logic unused_result;
    assign unused_result = ^io_copy_result;
    assign mis_now       = 1'b0;
`endif

    // Next-state and report computation; clear is applied first so a same-edge set wins.
    always_comb begin
        state_d       = state_q;
        captured_d    = captured_q;
        cnt_d         = cnt_q;
        mismatch_d    = mismatch_q;
        timing_leak_d = io_clear ? 1'b0 : timing_leak_q;
        value_leak_d  = io_clear ? 1'b0 : value_leak_q;
        timeout_d     = io_clear ? 1'b0 : timeout_q;
        done_d        = 1'b0;
        all_valid_d   = 1'b0;
        leak_skew_d   = leak_skew_q;
        txn_count_d   = txn_count_q;
        report        = 1'b0;
        rep_skew      = 8'd0;
        case (state_q)
            S_IDLE: begin
                if (|accept) begin
                    captured_d = accept;
                    mismatch_d = mis_now;
                    if (&accept) begin
                        report   = 1'b1;
                        rep_skew = 8'd0;
                    end else begin
                        state_d = S_COLLECT;
                        cnt_d   = 8'd0;
                    end
                end
            end
            S_COLLECT: begin
                captured_d = captured_q | accept;
                mismatch_d = mismatch_q | mis_now;
                if (&captured_d) begin
                    report   = 1'b1;
                    rep_skew = skew_sat;
                end else if (cnt_inc == 9'(MAX_SKEW)) begin
                    state_d       = S_HALT;
                    captured_d    = '0;
                    leak_skew_d   = 8'(MAX_SKEW);
                    timeout_d     = 1'b1;
                    timing_leak_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            S_REPORT: begin
                state_d    = S_IDLE;
                captured_d = '0;
                mismatch_d = 1'b0;
            end
            S_HALT: begin
                if (io_clear) begin
                    state_d    = S_IDLE;
                    captured_d = '0;
                    mismatch_d = 1'b0;
                    cnt_d      = 8'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (report) begin
            state_d       = S_REPORT;
            done_d        = 1'b1;
            all_valid_d   = (rep_skew == 8'd0);
            leak_skew_d   = rep_skew;
            timing_leak_d = timing_leak_d | (rep_skew != 8'd0);
            value_leak_d  = value_leak_d | mismatch_d;
            txn_count_d   = txn_count_q + 16'd1;
        end
    end

    // State machine registers with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            captured_q    <= '0;
            cnt_q         <= 8'd0;
            mismatch_q    <= 1'b0;
            timing_leak_q <= 1'b0;
            value_leak_q  <= 1'b0;
            timeout_q     <= 1'b0;
            done_q        <= 1'b0;
            all_valid_q   <= 1'b0;
            leak_skew_q   <= 8'd0;
            txn_count_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            captured_q    <= captured_d;
            cnt_q         <= cnt_d;
            mismatch_q    <= mismatch_d;
            timing_leak_q <= timing_leak_d;
            value_leak_q  <= value_leak_d;
            timeout_q     <= timeout_d;
            done_q        <= done_d;
            all_valid_q   <= all_valid_d;
            leak_skew_q   <= leak_skew_d;
            txn_count_q   <= txn_count_d;
        end
    end

    assign timingLeak     = timing_leak_q;
    assign valueLeak      = value_leak_q;
    assign timeout        = timeout_q;
    assign timingLeakDone = done_q;
    assign allValid       = all_valid_q;
    assign leakSkew       = leak_skew_q;
    assign txnCount       = txn_count_q;

endmodule

// File: tb/tb_selfcomp_checker.sv
// tb_selfcomp_checker: directed and randomized transactions against a per-transaction model of skew, divergence and sticky flags.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: ready is checked every cycle against which copies the model says are already captured.
module tb_selfcomp_checker;

    localparam int N  = 2;
    localparam int W  = 128;
    localparam int MS = 8;
`ifdef SELFCOMP_VALUE_CHECK_EN
    localparam bit VCHK = 1'b1;
`else
    localparam bit VCHK = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic           io_clear;
    logic [N-1:0]   io_copy_valid;
    logic [N-1:0]   io_copy_ready;
    logic [N*W-1:0] io_copy_result;
    logic           timingLeak, valueLeak, timeout, timingLeakDone, allValid;
    logic [7:0]     leakSkew;
    logic [15:0]    txnCount;

    int   total = 0;
    int   bad   = 0;
    logic exp_tl, exp_vl, exp_to;
    int   exp_txn;

    always #5 clock = ~clock;

    selfcomp_checker #(.NUM_COPIES(N), .DATA_W(W), .MAX_SKEW(MS)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_copy_valid  (io_copy_valid),
        .io_copy_result (io_copy_result),
        .io_copy_ready  (io_copy_ready),
        .io_clear       (io_clear),
        .timingLeak     (timingLeak),
        .valueLeak      (valueLeak),
        .timeout        (timeout),
        .timingLeakDone (timingLeakDone),
        .allValid       (allValid),
        .leakSkew       (leakSkew),
        .txnCount       (txnCount)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".timingLeak"}, 32'(timingLeak), 32'(exp_tl));
        chk({tag, ".valueLeak"},  32'(valueLeak),  32'(exp_vl));
        chk({tag, ".timeout"},    32'(timeout),    32'(exp_to));
    endtask

    // One transaction: copy i raises valid at offset d_i and holds it until the report.
    // clr_mode 1 pulses io_clear on the final accept edge, 2 during the report cycle.
    task automatic run_txn(input int d0, input int d1, input logic [W-1:0] r0,
                           input logic [W-1:0] r1, input int clr_mode);
        int   d[N];
        int   last, skew;
        logic mis;
        d[0] = d0;
        d[1] = d1;
        last = (d0 > d1) ? d0 : d1;
        skew = last - ((d0 < d1) ? d0 : d1);
        mis  = VCHK && (r0 != r1);
        io_copy_result = {r1, r0};
        for (int c = 0; c <= last; c++) begin
            for (int i = 0; i < N; i++) begin
                io_copy_valid[i] = (c >= d[i]);
                chk($sformatf("ready%0d_c%0d", i, c), 32'(io_copy_ready[i]), 32'(c <= d[i]));
            end
            if (c > 0) chk("done_mid", 32'(timingLeakDone), 32'd0);
            io_clear = (clr_mode == 1) && (c == last);
            step();
        end
        io_copy_valid = '0;
        io_clear      = 1'b0;
        if (clr_mode == 1) begin
            exp_tl = 1'b0;
            exp_vl = 1'b0;
            exp_to = 1'b0;
        end
        exp_tl  = exp_tl | (skew != 0);
        exp_vl  = exp_vl | mis;
        exp_txn = exp_txn + 1;
        chk("rep.done",     32'(timingLeakDone), 32'd1);
        chk("rep.allValid", 32'(allValid),       32'(skew == 0));
        chk("rep.leakSkew", 32'(leakSkew),       32'(skew));
        chk("rep.txnCount", 32'(txnCount),       32'(exp_txn[15:0]));
        chk("rep.ready",    32'(io_copy_ready),  32'd0);
        chk_flags("rep");
        io_clear = (clr_mode == 2);
        step();
        io_clear = 1'b0;
        if (clr_mode == 2) begin
            exp_tl = 1'b0;
            exp_vl = 1'b0;
            exp_to = 1'b0;
        end
        chk("post.done",     32'(timingLeakDone), 32'd0);
        chk("post.allValid", 32'(allValid),       32'd0);
        chk("post.ready",    32'(io_copy_ready),  32'(2'b11));
        chk_flags("post");
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".done"},     32'(timingLeakDone), 32'd0);
        chk({tag, ".allValid"}, 32'(allValid),       32'd0);
        chk({tag, ".leakSkew"}, 32'(leakSkew),       32'd0);
        chk({tag, ".txnCount"}, 32'(txnCount),       32'd0);
        chk({tag, ".ready"},    32'(io_copy_ready),  32'(2'b11));
        chk_flags(tag);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           pulses;
        reset          = 1'b1;
        io_clear       = 1'b0;
        io_copy_valid  = '0;
        io_copy_result = '0;
        exp_tl  = 1'b0;
        exp_vl  = 1'b0;
        exp_to  = 1'b0;
        exp_txn = 0;
        step();
        step();
        chk_reset_state("reset");
        reset = 1'b0;
        step();

        // Same-cycle equal results.
        run_txn(0, 0, 128'h5, 128'h5, 0);
        // Copy1 completes three cycles after copy0.
        repeat (3) step();
        run_txn(0, 3, 128'h5, 128'h5, 0);
        // Clear sticky flags, then same-cycle differing results.
        io_clear = 1'b1;
        step();
        io_clear = 1'b0;
        exp_tl = 1'b0;
        exp_vl = 1'b0;
        exp_to = 1'b0;
        chk_flags("clear1");
        run_txn(0, 0, 128'h5, 128'h6, 0);
        // Copy1 first, with a difference only in the top bit.
        run_txn(2, 0, {1'b1, 127'h0}, 128'h0, 0);

        // Randomized transactions, skew kept below the timeout.
        for (int t = 0; t < 60; t++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = ($urandom_range(0, 1) == 1) ? ra : (ra ^ (128'h1 << $urandom_range(0, 127)));
            run_txn($urandom_range(0, MS - 1), $urandom_range(0, MS - 1), ra, rb,
                    $urandom_range(0, 3) % 3);
        end

        // Timeout: copy1 never completes.
        io_clear = 1'b1;
        step();
        io_clear = 1'b0;
        exp_tl = 1'b0;
        exp_vl = 1'b0;
        exp_to = 1'b0;
        io_copy_result = {128'h0, 128'h9};
        io_copy_valid  = 2'b01;
        step();
        io_copy_valid = 2'b00;
        for (int k = 1; k <= MS; k++) begin
            chk($sformatf("to_wait%0d.timeout", k), 32'(timeout), 32'd0);
            chk($sformatf("to_wait%0d.ready", k), 32'(io_copy_ready), 32'(2'b10));
            chk($sformatf("to_wait%0d.done", k), 32'(timingLeakDone), 32'd0);
            step();
        end
        exp_tl = 1'b1;
        exp_to = 1'b1;
        chk_flags("halt");
        chk("halt.leakSkew", 32'(leakSkew),       32'(MS));
        chk("halt.ready",    32'(io_copy_ready),  32'(2'b11));
        chk("halt.done",     32'(timingLeakDone), 32'd0);
        chk("halt.txnCount", 32'(txnCount),       32'(exp_txn[15:0]));
        io_copy_valid = 2'b11;
        step();
        io_copy_valid = 2'b00;
        chk("drain.ready",    32'(io_copy_ready),  32'(2'b11));
        chk("drain.done",     32'(timingLeakDone), 32'd0);
        chk("drain.txnCount", 32'(txnCount),       32'(exp_txn[15:0]));
        chk_flags("drain");
        io_clear = 1'b1;
        step();
        io_clear = 1'b0;
        exp_tl = 1'b0;
        exp_to = 1'b0;
        chk_flags("halt_clear");
        chk("halt_clear.ready", 32'(io_copy_ready), 32'(2'b11));
        run_txn(0, 0, 128'h7, 128'h7, 0);

        // Reset in the middle of a transaction.
        run_txn(1, 0, 128'h3, 128'h3, 0);
        io_copy_valid = 2'b01;
        step();
        io_copy_valid = 2'b00;
        step();
        step();
        reset = 1'b1;
        step();
        reset   = 1'b0;
        exp_tl  = 1'b0;
        exp_vl  = 1'b0;
        exp_to  = 1'b0;
        exp_txn = 0;
        chk_reset_state("midreset");
        run_txn(0, 0, 128'h5, 128'h5, 0);

        // Back-to-back same-cycle transactions: one report every two cycles.
        pulses = 0;
        io_copy_result = {128'hA, 128'hA};
        io_copy_valid  = 2'b11;
        for (int cyc = 0; cyc < 200; cyc++) begin
            step();
            if (cyc == 199) io_copy_valid = 2'b00;
            if (timingLeakDone) pulses++;
            chk($sformatf("burst%0d.done", cyc), 32'(timingLeakDone), 32'((cyc % 2) == 0));
        end
        exp_txn = exp_txn + 100;
        chk("burst.pulses",   32'(pulses),   32'd100);
        chk("burst.txnCount", 32'(txnCount), 32'(exp_txn[15:0]));
        chk_flags("burst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
